// File: rtl/button_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : button_counter_if
// Purpose  : Button inputs, counter controls and event outputs of button_counter.
// Revision : 1.0
// ============================================================================
interface button_counter_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0] d_i;
    logic                mode_i;
    logic                clear_i;
    logic [CHANNELS-1:0] db_o;
    logic [CHANNELS-1:0] press_o;
    logic [CHANNELS-1:0] release_o;
    logic [CNT_W-1:0]    count_o;
    logic                wrap_o;

    modport master (
        output d_i, mode_i, clear_i,
        input  db_o, press_o, release_o, count_o, wrap_o
    );

    modport slave (
        input  d_i, mode_i, clear_i,
        output db_o, press_o, release_o, count_o, wrap_o
    );
endinterface
`default_nettype wire

// File: rtl/button_counter.sv
`default_nettype none
// ============================================================================
// Module   : button_counter
// Purpose  : Synchronise/debounce CHANNELS buttons, emit press/release pulses,
//            and count events in any-press or up/down mode (wrap or saturate).
// Revision : 1.0
// ============================================================================
module button_counter #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8,
    parameter int SATURATE      = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    button_counter_if.slave  bus
);
    localparam int                STAB_W    = $clog2(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic [CHANNELS-1:0] db_q, db_d;
    logic [CHANNELS-1:0] press_q, press_d;
    logic [CHANNELS-1:0] release_q, release_d;
    logic [STAB_W-1:0]   stab_q [CHANNELS];
    logic [STAB_W-1:0]   stab_d [CHANNELS];
    logic [CNT_W-1:0]    count_q, count_d;
    logic                wrap_q, wrap_d;
    logic                ch1_press;
    logic                step_up, step_dn;

    always_comb begin
        db_d      = db_q;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            stab_d[k] = '0;
            if (sync2_q[k] != db_q[k]) begin
                if (stab_q[k] == STAB_LAST) begin
                    db_d[k]      = sync2_q[k];
                    press_d[k]   = sync2_q[k];
                    release_d[k] = db_q[k];
                end else begin
                    stab_d[k] = stab_q[k] + 1'b1;
                end
            end
        end
    end

    if (CHANNELS > 1) begin : g_dn_ch
        assign ch1_press = press_q[1];
    end else begin : g_no_dn_ch
        assign ch1_press = 1'b0;
    end

    // Simultaneous ch0/ch1 presses in up/down mode cancel each other.
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        if (bus.mode_i) begin
            step_up = press_q[0] & ~ch1_press;
            step_dn = ch1_press & ~press_q[0];
        end else begin
            step_up = |press_q;
        end

        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clear_i) begin
            count_d = '0;
        end else if (step_up) begin
            if (&count_q) begin
                wrap_d  = 1'b1;
                count_d = (SATURATE != 0) ? count_q : '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (step_dn) begin
            if (count_q == '0) begin
                wrap_d  = 1'b1;
                count_d = (SATURATE != 0) ? count_q : '1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            press_q   <= '0;
            release_q <= '0;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                stab_q[k] <= '0;
            end
        end else begin
            sync1_q   <= bus.d_i;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            for (int k = 0; k < CHANNELS; k++) begin
                stab_q[k] <= stab_d[k];
            end
        end
    end

    assign bus.db_o      = db_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.count_o   = count_q;
    assign bus.wrap_o    = wrap_q;
endmodule
`default_nettype wire

// File: tb/tb_button_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_counter
// Purpose  : Randomised scoreboard bench for button_counter (wrap and saturate).
// Revision : 1.0
// ============================================================================
module tb_button_counter;
    localparam int S    = 4;
    localparam int HOLD = S + 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] d;
    logic       mode;
    logic       clr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] db, pr, rl;
        logic [7:0] c0, c1;
        logic       w0, w1;
    } exp_t;
    exp_t sb[$];

    button_counter_if #(.CHANNELS(4), .CNT_W(8)) if0 ();
    button_counter_if #(.CHANNELS(4), .CNT_W(8)) if1 ();

    assign if0.d_i = d;  assign if0.mode_i = mode;  assign if0.clear_i = clr;
    assign if1.d_i = d;  assign if1.mode_i = mode;  assign if1.clear_i = clr;

    button_counter #(.CHANNELS(4), .STABLE_CYCLES(S), .CNT_W(8), .SATURATE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if0));
    button_counter #(.CHANNELS(4), .STABLE_CYCLES(S), .CNT_W(8), .SATURATE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a level flips once the last S synchronised samples all disagree with it.
    logic [3:0]   m_db, m_pr, m_rl, dd1, dd2;
    logic [7:0]   m_c0, m_c1;
    logic [S-1:0] hist [4];
    int           nval [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_db = '0; m_pr = '0; m_rl = '0; dd1 = '0; dd2 = '0;
            m_c0 = '0; m_c1 = '0;
            for (int k = 0; k < 4; k++) begin hist[k] = '0; nval[k] = 0; end
            sb.delete();
        end else begin
            exp_t       e;
            int         step, t;
            logic [7:0] c0n, c1n;
            logic       w0, w1;
            logic [3:0] npr, nrl;
            cyc++;
            c0n = m_c0; c1n = m_c1; w0 = 1'b0; w1 = 1'b0;
            if (clr) begin
                c0n = 8'd0; c1n = 8'd0;
            end else begin
                if (!mode) step = (m_pr != 4'd0) ? 1 : 0;
                else       step = int'(m_pr[0]) - int'(m_pr[1]);
                if (step != 0) begin
                    t = int'(m_c0) + step;
                    if (t < 0 || t > 255) begin w0 = 1'b1; t = (t + 256) % 256; end
                    c0n = 8'(t);
                    t = int'(m_c1) + step;
                    if (t < 0 || t > 255) begin w1 = 1'b1; t = int'(m_c1); end
                    c1n = 8'(t);
                end
            end
            npr = '0; nrl = '0;
            for (int k = 0; k < 4; k++) begin
                hist[k] = {hist[k][S-2:0], dd2[k]};
                if (nval[k] < S) nval[k]++;
                if (nval[k] == S && hist[k] == {S{~m_db[k]}}) begin
                    m_db[k] = ~m_db[k];
                    npr[k]  = m_db[k];
                    nrl[k]  = ~m_db[k];
                end
            end
            dd2 = dd1; dd1 = d;
            if (npr != 0 || nrl != 0 || w0 || w1 || c0n != m_c0 || c1n != m_c1) begin
                e.cyc = cyc; e.db = m_db; e.pr = npr; e.rl = nrl;
                e.c0 = c0n; e.c1 = c1n; e.w0 = w0; e.w1 = w1;
                sb.push_back(e);
            end
            m_pr = npr; m_rl = nrl; m_c0 = c0n; m_c1 = c1n;
        end
    end

    // Monitor: any DUT event or count change pops and checks the next expectation.
    logic [7:0] prev0, prev1;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev0 = '0; prev1 = '0;
        end else begin
            exp_t e;
            logic trig;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL missed_event: expected event at edge %0d not seen (now edge %0d)", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            trig = (|if0.press_o) | (|if0.release_o) | (|if1.press_o) | (|if1.release_o) |
                   if0.wrap_o | if1.wrap_o | (if0.count_o != prev0) | (if1.count_o != prev1);
            if (trig) begin
                n_cmp++;
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    e = sb.pop_front();
                    if (if0.db_o !== e.db || if0.press_o !== e.pr || if0.release_o !== e.rl ||
                        if1.db_o !== e.db || if1.press_o !== e.pr || if1.release_o !== e.rl ||
                        if0.count_o !== e.c0 || if1.count_o !== e.c1 ||
                        if0.wrap_o !== e.w0 || if1.wrap_o !== e.w1) begin
                        n_bad++;
                        $display("FAIL event@%0d: got db=%h pr=%h rl=%h c0=%0d c1=%0d w0=%b w1=%b (db1=%h pr1=%h rl1=%h) want db=%h pr=%h rl=%h c0=%0d c1=%0d w0=%b w1=%b",
                                 cyc, if0.db_o, if0.press_o, if0.release_o, if0.count_o, if1.count_o,
                                 if0.wrap_o, if1.wrap_o, if1.db_o, if1.press_o, if1.release_o,
                                 e.db, e.pr, e.rl, e.c0, e.c1, e.w0, e.w1);
                    end
                end else begin
                    n_bad++;
                    $display("FAIL unexpected_event@%0d: got pr=%h rl=%h c0=%0d c1=%0d w0=%b w1=%b, want no event",
                             cyc, if0.press_o, if0.release_o, if0.count_o, if1.count_o, if0.wrap_o, if1.wrap_o);
                end
            end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
                n_cmp++; n_bad++;
                e = sb.pop_front();
                $display("FAIL missing_event@%0d: got no event, want pr=%h rl=%h c0=%0d c1=%0d w0=%b w1=%b",
                         cyc, e.pr, e.rl, e.c0, e.c1, e.w0, e.w1);
            end
            prev0 = if0.count_o;
            prev1 = if1.count_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] mask);
        d = mask; tick(HOLD);
        d = 4'b0; tick(HOLD);
    endtask

    task automatic clear_count();
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (if0.db_o !== 0 || if0.press_o !== 0 || if0.release_o !== 0 || if0.count_o !== 0 || if0.wrap_o !== 0 ||
            if1.db_o !== 0 || if1.press_o !== 0 || if1.release_o !== 0 || if1.count_o !== 0 || if1.wrap_o !== 0) begin
            n_bad++;
            $display("FAIL %s: got db=%h pr=%h rl=%h c0=%0d c1=%0d w=%b%b, want all zero",
                     name, if0.db_o, if0.press_o, if0.release_o, if0.count_o, if1.count_o, if0.wrap_o, if1.wrap_o);
        end
    endtask

    // d_i[0] must already be driven high; first_edge is the first sampling edge.
    task automatic check_rise_latency(input string name, input int first_edge);
        int seen = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (if0.db_o[0]) begin seen = cyc; break; end
        end
        n_cmp++;
        if (seen < 0 || seen - first_edge + 1 != 2 + S) begin
            n_bad++;
            $display("FAIL %s: got db_o[0] rise at edge %0d of window, want edge %0d", name,
                     (seen < 0) ? -1 : seen - first_edge + 1, 2 + S);
        end
    endtask

    initial begin
        d = 4'b0; mode = 1'b0; clr = 1'b0; rst_n = 1'b0;
        tick(3);
        check_zero("reset_state");
        rst_n = 1'b1;
        tick(2);

        // Glitch rejection followed by a qualifying press.
        d = 4'b0001; tick(3);
        d = 4'b0000; tick(10);
        d = 4'b0001;
        check_rise_latency("glitch_then_hold_latency", cyc + 1);
        tick(2);
        d = 4'b0000; tick(HOLD);

        // Simultaneous presses in any-press mode.
        clear_count();
        repeat (5) press(4'b0001);
        press(4'b1111);

        // Up/down mode.
        clear_count();
        mode = 1'b1;
        repeat (3) press(4'b0001);
        press(4'b0010);
        press(4'b0011);
        press(4'b0100);

        // Underflow then overflow of both policies.
        clear_count();
        press(4'b0010);
        press(4'b0001);
        mode = 1'b0;
        repeat (260) press(4'($urandom_range(1, 15)));

        // Clear coinciding with a press pulse.
        clear_count();
        repeat (7) press(4'b0100);
        d = 4'b0001;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if (if0.press_o[0]) begin hit = 1'b1; break; end
            end
            clr = 1'b1; tick(1); clr = 1'b0;
            n_cmp++;
            if (!hit || if0.count_o !== 8'd0 || if1.count_o !== 8'd0 || if0.wrap_o !== 1'b0) begin
                n_bad++;
                $display("FAIL clear_vs_press: got seen=%0b c0=%0d c1=%0d wrap=%b, want seen=1 c0=0 c1=0 wrap=0",
                         hit, if0.count_o, if1.count_o, if0.wrap_o);
            end
        end
        d = 4'b0000; tick(HOLD);

        // Random stimulus.
        for (int i = 0; i < 300; i++) begin
            d    = 4'($urandom_range(0, 15));
            mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin clr = 1'b1; tick(1); clr = 1'b0; end
            tick($urandom_range(1, 10));
        end
        d = 4'b0; tick(HOLD);

        // Reset in the middle of a debounce window.
        mode = 1'b0;
        clear_count();
        repeat (9) press(4'b1000);
        d = 4'b0001; tick(2 + S + 2);
        d = 4'b0000; tick(4);
        rst_n = 1'b0; #1;
        check_zero("reset_mid_debounce");
        tick(2);
        d = 4'b0001; rst_n = 1'b1;
        check_rise_latency("post_reset_latency", cyc + 1);
        d = 4'b0000; tick(HOLD + 4);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire

// File: doc/button_counter.md
# button_counter

Multi-channel, parametrised button front end: synchronises and debounces `CHANNELS` raw inputs, produces one-cycle press/release events per channel, and drives an event counter with a selectable counting mode and a selectable overflow policy. It sits between board push-buttons and user logic such as the LED bank. It replaces per-button debouncer instances plus an ad-hoc increment counter with a single configurable block.

## Interface

Parameters:
- `CHANNELS`, 4: number of button inputs, at least 1.
- `STABLE_CYCLES`, 16: consecutive synchronised cycles an input must differ from the debounced level before that level flips, at least 2.
- `CNT_W`, 8: event counter width, at least 2.
- `SATURATE`, 0: 0 means the counter wraps modulo 2^CNT_W; 1 means it clamps at 0 and at all-ones.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `d_i` in CHANNELS: raw, asynchronous button levels (1 = pressed).
- `mode_i` in 1: 0 = any-press mode, 1 = up/down mode.
- `clear_i` in 1: synchronous counter clear.
- `db_o` out CHANNELS: debounced levels.
- `press_o` out CHANNELS: one-cycle pulse on a debounced 0→1 transition.
- `release_o` out CHANNELS: one-cycle pulse on a debounced 1→0 transition.
- `count_o` out CNT_W: event counter.
- `wrap_o` out 1: one-cycle pulse when a step wraps or is clamped.

## Operation

- Reset, asynchronous on `rst_ni` low: all synchroniser flops, stability counters, `db_o`, `press_o`, `release_o`, `count_o` and `wrap_o` are 0. Any debounce in progress is discarded.
- Per channel:
  - `d_i[k]` passes through a 2-flop synchroniser; `s[k]` is the second stage.
  - The stability counter has width $clog2(STABLE_CYCLES).
  - If `s[k] == db_o[k]`, the counter resets to 0.
  - Otherwise, if the counter equals STABLE_CYCLES-1, then `db_o[k]` takes the value of `s[k]` and the counter resets to 0.
  - Otherwise the counter increments.
  - A disagreement that lasts fewer than STABLE_CYCLES cycles is fully rejected.
- `press_o[k]` and `release_o[k]` are registered. They assert on the same edge on which `db_o[k]` flips, for exactly one cycle.
- Counter update, once per cycle, evaluated in priority order:
  1. If `clear_i` = 1, then `count_o` is 0. This overrides any simultaneous event. `wrap_o` is 0.
  2. If `mode_i` = 0 and any `press_o` bit is 1, then the step is +1. This is one increment regardless of how many channels press together.
  3. If `mode_i` = 1, channel 0 press gives +1 and channel 1 press gives -1. Both in the same cycle give no change. Channels 2 and above are ignored. If CHANNELS = 1, only +1 is possible.
  4. Otherwise `count_o` holds.
- Width and overflow rules:
  - A +1 step from all-ones, or a -1 step from 0, is an overflow step.
  - With SATURATE = 0, the count wraps: all-ones becomes 0, and 0 becomes all-ones.
  - With SATURATE = 1, the count holds its value.
  - In both cases `wrap_o` pulses on the same edge that the count updates (or would have updated).
- `mode_i` is sampled every cycle. A change takes effect on the next event, and in-flight press pulses are evaluated under the mode present in their cycle.

## Timing

- Input to debounced output: `d_i` changes and then holds. `s` follows at the 2nd rising edge. `db_o` and `press_o`/`release_o` follow STABLE_CYCLES edges after that. Total latency is 2+STABLE_CYCLES edges from the first sampling edge.
- `count_o` and `wrap_o` update one edge after the `press_o` pulse, so press-to-count latency is 3+STABLE_CYCLES edges.
- `clear_i` acts on the next edge, which gives 1-cycle latency.
- A bounce that returns to the old level before the threshold edge resets the counter and leaves `db_o` unchanged.
- `rst_ni` assertion is immediate and asynchronous. Deassertion is expected synchronous to `clk_i` (external reset synchroniser). The first sample is taken on the first edge after deassertion.

## Test plan

- Glitch rejection, with STABLE_CYCLES = 4: `d_i[0]` held high for 3 synchronised cycles, then low. Required: `db_o` stays 0 and `press_o` never pulses. Then hold high for 8 cycles. Required: `db_o[0]` rises 6 edges after the first sampling edge, with a single `press_o[0]` pulse, and `count_o` becomes 1 one edge later.
- Simultaneous presses, mode 0: channels 0–3 press in the same cycle. Required: `count_o` 5→6, a single +1 step. Releases then produce `release_o` = 4'b1111 for one cycle and no count change.
- Up/down, mode 1: press ch0 three times from 0, giving 3. Press ch1 once, giving 2. Press ch0 and ch1 together, giving 2. Press ch2, giving 2.
- Overflow, CNT_W = 8:
  - SATURATE = 0, count 255 plus a press: required count 0 and a 1-cycle `wrap_o`. Count 0 plus a ch1 press in mode 1: required 255.
  - SATURATE = 1: 255 stays 255 and 0 stays 0, each with a `wrap_o` pulse.
- `clear_i` together with `press_o`: count 7, `clear_i` = 1 in the cycle in which press is 1. Required: count 0 and no `wrap_o`.
- Reset mid-debounce: `rst_ni` low 2 cycles into a 4-cycle stability window with `db_o` = 1 and count 9. Required: all outputs 0 immediately. After release with `d_i` held high, `db_o` rises after the full 2+STABLE_CYCLES edges.
